iob_native_wb_bridge: RTL

- Upstream stage of the Ethernet MAC core. Converts the native valid/address/wdata/wstrb/rdata/ready register interface into single Wishbone classic-cycle master transfers.
- Its Wishbone master port drives the MAC's Wishbone register slave.
- Adds a bus-timeout watchdog and sticky error/overrun status so a hung or erroring slave cannot stall the native master.

---
 rtl/iob_native_wb_bridge_if.sv | 33 +++
 rtl/iob_native_wb_bridge.sv | 123 ++++++++++++
 2 files changed

// File: rtl/iob_native_wb_bridge_if.sv
// Bundles the native request/response signals with the Wishbone master signals.
// "master" is the bridge's view; "slave" is the view of the native requester and the Wishbone slave.
interface iob_native_wb_bridge_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    logic [ADDR_W+1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic                  wb_we_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        input  valid, address, wdata, wstrb, wb_dat_i, wb_ack_i, wb_err_i,
        output rdata, ready, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output valid, address, wdata, wstrb, wb_dat_i, wb_ack_i, wb_err_i,
        input  rdata, ready, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/iob_native_wb_bridge.sv
// Native valid/ready register port to single Wishbone classic-cycle master transfers,
// with a bus-timeout watchdog and sticky error/overrun flags.
module iob_native_wb_bridge #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    iob_native_wb_bridge_if.master bus,
    input  logic                   err_clr_i,
    output logic                   err_o,
    output logic                   ovr_o
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ovr_q, ovr_d;
    logic                set_err;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    adr_d   = bus.address;
                    dat_d   = bus.wdata;
                    we_d    = |bus.wstrb;
                    sel_d   = (|bus.wstrb) ? bus.wstrb : '1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + 1'b1;
                // Error outranks a simultaneous ack; timeout only fires if neither arrived.
                if (bus.wb_err_i) begin
                    rdata_d = '1;
                    set_err = 1'b1;
                    state_d = DONE;
                end else if (bus.wb_ack_i) begin
                    rdata_d = we_q ? '0 : bus.wb_dat_i;
                    state_d = DONE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rdata_d = '1;
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = err_clr_i ? 1'b0 : (err_q | set_err);
        ovr_d = err_clr_i ? 1'b0 : (ovr_q | (bus.valid && (state_q != IDLE)));
    end

    always_comb begin
        bus.wb_cyc_o = 1'b0;
        bus.wb_stb_o = 1'b0;
        bus.wb_we_o  = 1'b0;
        bus.wb_adr_o = '0;
        bus.wb_dat_o = '0;
        bus.wb_sel_o = '0;
        bus.ready    = 1'b0;
        bus.rdata    = '0;
        if (state_q == BUS) begin
            bus.wb_cyc_o = 1'b1;
            bus.wb_stb_o = 1'b1;
            bus.wb_we_o  = we_q;
            bus.wb_adr_o = {adr_q, 2'b00};
            bus.wb_dat_o = dat_q;
            bus.wb_sel_o = sel_q;
        end
        if (state_q == DONE) begin
            bus.ready = 1'b1;
            bus.rdata = rdata_q;
        end
    end

    assign err_o = err_q;
    assign ovr_o = ovr_q;
endmodule
